voice_controller: RTL and testbench



---
 rtl/voice_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_voice_controller.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_controller.sv
// voice_controller: time-multiplexed DDS sawtooth + ADSR voice engine.
// Optional `VELOCITY_EN: per-voice velocity latched on note-on scales output.
module voice_controller #(
  parameter int unsigned NUM_VOICES    = 256,
  parameter logic [15:0] ATTACK_STEP   = 16'd64,
  parameter logic [15:0] DECAY_STEP    = 16'd16,
  parameter logic [15:0] SUSTAIN_LEVEL = 16'hC000,
  parameter logic [15:0] RELEASE_STEP  = 16'd8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_SPI_note_status,
  input  logic [7:0]         i_SPI_voice_index,
  input  logic [31:0]        i_SPI_tuning_code,
  input  logic [7:0]         i_SPI_velocity,
  input  logic               i_SPI_flag_dds,
  input  logic               i_SPI_flag_adsr,
  output logic signed [23:0] o_mixed_sample
);

  localparam int NV = int'(NUM_VOICES);
  localparam int VW = $clog2(NUM_VOICES);
  localparam logic [VW-1:0] LAST = VW'(NUM_VOICES - 1);

  typedef enum logic [2:0] {
    IDLE, ATTACK, DECAY, SUSTAIN, RELEASE
  } env_t;

  logic [31:0]           tuning [NUM_VOICES];
  logic [31:0]           phase  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate;
  env_t                  env    [NUM_VOICES];
  logic [15:0]           level  [NUM_VOICES];

  logic [VW-1:0] v;
  logic [VW-1:0] idx;
  logic [7:0]    unused_idx;

  logic [31:0] phase_nxt;
  env_t        env_nxt;
  logic [15:0] lvl_nxt;
  logic [16:0] att_sum;
  logic        dec_done;
  logic        rel_done;

  logic signed [15:0] s1_wave;
  logic [15:0]        s1_level;
  logic               s1_last;
  logic signed [32:0] env_prod;
  logic signed [15:0] base_sample;
  logic signed [15:0] voice_sample;
  logic signed [15:0] s2_sample;
  logic               s2_last;
  logic signed [23:0] acc;

  // Upper index bits beyond the voice count are don't-care.
  assign idx        = i_SPI_voice_index[VW-1:0];
  assign unused_idx = i_SPI_voice_index;

`ifdef VELOCITY_EN
  logic [7:0]         vel [NUM_VOICES];
  logic [7:0]         s1_vel;
  logic signed [24:0] vel_prod;

  // Velocity is captured only on note-on.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NV; i++) vel[i] <= '0;
    end else if (i_SPI_flag_adsr && i_SPI_note_status) begin
      vel[idx] <= i_SPI_velocity;
    end
  end
`else
  logic [7:0] unused_vel;
  assign unused_vel = i_SPI_velocity;
`endif

  // Round-robin scan pointer, one voice per clock.
  always_ff @(posedge i_clk) begin
    if (i_reset) v <= '0;
    else         v <= v + VW'(1);
  end

  // Tuning words change only through the command strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NV; i++) tuning[i] <= '0;
    end else if (i_SPI_flag_dds) begin
      tuning[idx] <= i_SPI_tuning_code;
    end
  end

  // Gates change only through the command strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset)              gate      <= '0;
    else if (i_SPI_flag_adsr) gate[idx] <= i_SPI_note_status;
  end

  // Scan write-back: phase and envelope state of the scanned voice.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NV; i++) begin
        phase[i] <= '0;
        env[i]   <= IDLE;
        level[i] <= '0;
      end
    end else begin
      phase[v] <= phase_nxt;
      env[v]   <= env_nxt;
      level[v] <= lvl_nxt;
    end
  end

  // Next phase and envelope step for the scanned voice.
  always_comb begin
    phase_nxt = phase[v] + tuning[v];
    env_nxt   = env[v];
    lvl_nxt   = level[v];
    att_sum   = {1'b0, level[v]} + {1'b0, ATTACK_STEP};
    dec_done  = {1'b0, level[v]} <=
                ({1'b0, SUSTAIN_LEVEL} + {1'b0, DECAY_STEP});
    // Landing exactly on zero also ends the release.
    rel_done  = level[v] <= RELEASE_STEP;
    unique case (env[v])
      IDLE: begin
        if (gate[v]) env_nxt = ATTACK;
      end
      ATTACK: begin
        if (!gate[v]) begin
          env_nxt = RELEASE;
        end else if (att_sum[16]) begin
          lvl_nxt = 16'hFFFF;
          env_nxt = DECAY;
        end else begin
          lvl_nxt = att_sum[15:0];
        end
      end
      DECAY: begin
        if (!gate[v]) begin
          env_nxt = RELEASE;
        end else if (dec_done) begin
          lvl_nxt = SUSTAIN_LEVEL;
          env_nxt = SUSTAIN;
        end else begin
          lvl_nxt = level[v] - DECAY_STEP;
        end
      end
      SUSTAIN: begin
        if (!gate[v]) env_nxt = RELEASE;
      end
      RELEASE: begin
        if (gate[v]) begin
          env_nxt = ATTACK;
        end else if (rel_done) begin
          lvl_nxt = '0;
          env_nxt = IDLE;
        end else begin
          lvl_nxt = level[v] - RELEASE_STEP;
        end
      end
      default: env_nxt = IDLE;
    endcase
  end

  // Stage 1: sawtooth, envelope level and end-of-frame marker.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_wave  <= '0;
      s1_level <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_wave  <= phase_nxt[31:16];
      s1_level <= lvl_nxt;
      s1_last  <= (v == LAST);
    end
  end

`ifdef VELOCITY_EN
  // Stage 1 companion: velocity of the scanned voice.
  always_ff @(posedge i_clk) begin
    if (i_reset) s1_vel <= '0;
    else         s1_vel <= vel[v];
  end
`endif

  // Envelope (and optional velocity) scaling of the stage-1 wave.
  always_comb begin
    env_prod     = 33'(s1_wave) * 33'($signed({1'b0, s1_level}));
    base_sample  = 16'(env_prod >>> 16);
    voice_sample = base_sample;
`ifdef VELOCITY_EN
    vel_prod     = 25'(base_sample) * 25'($signed({1'b0, s1_vel}));
    voice_sample = 16'(vel_prod >>> 8);
`endif
  end

  // Stage 2: scaled voice sample.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s2_sample <= '0;
      s2_last   <= 1'b0;
    end else begin
      s2_sample <= voice_sample;
      s2_last   <= s1_last;
    end
  end

  // Stage 3: accumulate; publish and clear on the frame's last voice.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc            <= '0;
      o_mixed_sample <= '0;
    end else if (s2_last) begin
      o_mixed_sample <= acc + 24'(s2_sample);
      acc            <= '0;
    end else begin
      acc <= acc + 24'(s2_sample);
    end
  end

endmodule

// File: tb/tb_voice_controller.sv
// tb_voice_controller: random and directed stimulus against a
// per-frame behavioural model of the voice engine.
`timescale 1ns/1ps
module tb_voice_controller;

  localparam int NV    = 16;
  localparam int ATT_I = 4096;
  localparam int DEC_I = 2048;
  localparam int SUS_I = 49152;
  localparam int REL_I = 1024;
  localparam int M_IDLE = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic note = 1'b0;
  logic fd = 1'b0;
  logic fa = 1'b0;
  logic [7:0] idx = '0;
  logic [7:0] vel = '0;
  logic [31:0] tun = '0;
  logic signed [23:0] mix;

  int total = 0;
  int bad = 0;

  voice_controller #(
    .NUM_VOICES(NV),
    .ATTACK_STEP(16'(ATT_I)),
    .DECAY_STEP(16'(DEC_I)),
    .SUSTAIN_LEVEL(16'(SUS_I)),
    .RELEASE_STEP(16'(REL_I))
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_SPI_note_status(note),
    .i_SPI_voice_index(idx),
    .i_SPI_tuning_code(tun),
    .i_SPI_velocity(vel),
    .i_SPI_flag_dds(fd),
    .i_SPI_flag_adsr(fa),
    .o_mixed_sample(mix)
  );

  always #5 clk = ~clk;

  logic [31:0] m_tun [NV];
  logic [31:0] m_ph  [NV];
  bit          m_gate[NV];
  int          m_st  [NV];
  int          m_lvl [NV];
  int          m_vel [NV];
  int cyc, facc, fa12, exp_out, exp_a;
  int track = 12;

  typedef struct {
    int due;
    int val;
    int va;
  } pend_t;
  pend_t pq[$];

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_tun[i] = '0; m_ph[i] = '0; m_gate[i] = 1'b0;
      m_st[i] = M_IDLE; m_lvl[i] = 0; m_vel[i] = 0;
    end
    cyc = 0; facc = 0; fa12 = 0; exp_out = 0; exp_a = 0;
    pq.delete();
  endfunction

  function automatic int voice_scan(int w);
    int wave;
    longint s;
    logic [15:0] hi;
    m_ph[w] = m_ph[w] + m_tun[w];
    hi = m_ph[w][31:16];
    wave = (hi >= 16'h8000) ? int'(hi) - 65536 : int'(hi);
    case (m_st[w])
      M_IDLE: if (m_gate[w]) m_st[w] = M_ATT;
      M_ATT:
        if (!m_gate[w]) m_st[w] = M_REL;
        else begin
          m_lvl[w] = m_lvl[w] + ATT_I;
          if (m_lvl[w] > 65535) begin m_lvl[w] = 65535; m_st[w] = M_DEC; end
        end
      M_DEC:
        if (!m_gate[w]) m_st[w] = M_REL;
        else begin
          m_lvl[w] = m_lvl[w] - DEC_I;
          if (m_lvl[w] <= SUS_I) begin m_lvl[w] = SUS_I; m_st[w] = M_SUS; end
        end
      M_SUS: if (!m_gate[w]) m_st[w] = M_REL;
      M_REL:
        if (m_gate[w]) m_st[w] = M_ATT;
        else begin
          m_lvl[w] = m_lvl[w] - REL_I;
          if (m_lvl[w] <= 0) begin m_lvl[w] = 0; m_st[w] = M_IDLE; end
        end
      default: ;
    endcase
    s = (longint'(wave) * longint'(m_lvl[w])) >>> 16;
`ifdef VELOCITY_EN
    s = (s * longint'(m_vel[w])) >>> 8;
`endif
    return int'(s);
  endfunction

  // One clock: model the scan + strobes of this cycle, then advance.
  task automatic tick();
    int w = cyc % NV;
    int s;
    int t = int'(idx) % NV;
    s = voice_scan(w);
    facc += s;
    if (w == track) fa12 = s;
    if (fd) m_tun[t] = tun;
    if (fa) begin
      m_gate[t] = note;
      if (note) m_vel[t] = int'(vel);
    end
    if (w == NV - 1) begin
      pq.push_back('{due: cyc + 3, val: facc, va: fa12});
      facc = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      exp_out = pq[0].val;
      exp_a = pq[0].va;
      void'(pq.pop_front());
    end
  endtask

  task automatic do_reset(int n);
    rst = 1'b1; fd = 1'b0; fa = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(5);
    total++;
    if (mix !== 24'sd0) begin
      bad++; $display("FAIL reset_out got=%0d want=0", mix);
    end
    repeat (3 * NV) begin
      tick();
      total++;
      if (mix !== 24'sd0) begin
        bad++; $display("FAIL idle_frames got=%0d want=0 cyc=%0d", mix, cyc);
      end
    end
  endtask

  task automatic test_note_on();
    bit seen = 0;
    idx = 8'd253; tun = 32'd20_000_000; note = 1'b1;
    vel = 8'($urandom); fd = 1'b1; fa = 1'b1;
    tick();
    fd = 1'b0; fa = 1'b0;
    repeat (3 * NV + 3) begin
      tick();
      if (mix !== 24'sd0) seen = 1;
      total++;
      if (mix !== 24'(exp_out)) begin
        bad++; $display("FAIL note_on got=%0d want=%0d cyc=%0d", mix, exp_out, cyc);
      end
    end
    total++;
    if (seen !== 1'b1) begin
      bad++; $display("FAIL note_on_audible got=%0d want=1", seen);
    end
  endtask

  task automatic test_hold();
    bit pos = 0, neg = 0;
    int peak = 0, a;
    repeat (300 * NV) begin
      tick();
      a = (mix < 0) ? -int'(mix) : int'(mix);
      if (a > peak) peak = a;
      if (mix > 0) pos = 1;
      if (mix < 0) neg = 1;
      total++;
      if (mix !== 24'(exp_out)) begin
        bad++; $display("FAIL hold got=%0d want=%0d cyc=%0d", mix, exp_out, cyc);
      end
    end
    total++;
    if (!(pos && neg)) begin
      bad++; $display("FAIL hold_oscillate got=%0d%0d want=11", pos, neg);
    end
    total++;
    if (peak > 32767) begin
      bad++; $display("FAIL hold_peak got=%0d want<=32767", peak);
    end
  endtask

  task automatic test_note_off();
    idx = 8'd253; note = 1'b0; fa = 1'b1;
    tick();
    fa = 1'b0;
    repeat (55 * NV) begin
      tick();
      total++;
      if (mix !== 24'(exp_out)) begin
        bad++; $display("FAIL release got=%0d want=%0d cyc=%0d", mix, exp_out, cyc);
      end
    end
    total++;
    if (mix !== 24'sd0) begin
      bad++; $display("FAIL release_silent got=%0d want=0", mix);
    end
  endtask

  task automatic test_pair();
    do_reset(2);
    tun = $urandom; note = 1'b1; fd = 1'b1; fa = 1'b1;
    idx = 8'd252; tick();
    idx = 8'd253; tick();
    fd = 1'b0; fa = 1'b0;
    repeat (40 * NV) begin
      tick();
      total++;
      if (mix !== 24'(exp_out)) begin
        bad++; $display("FAIL pair got=%0d want=%0d cyc=%0d", mix, exp_out, cyc);
      end
      total++;
      if (mix !== 24'(2 * exp_a)) begin
        bad++; $display("FAIL pair_double got=%0d want=%0d", mix, 2 * exp_a);
      end
    end
  endtask

  task automatic test_collision();
    do_reset(2);
    idx = 8'd5; tun = 32'h0300_0000; note = 1'b1; vel = 8'd255;
    fd = 1'b1; fa = 1'b1;
    tick();
    fd = 1'b0; fa = 1'b0;
    repeat (NV) tick();
    while (cyc % NV != 5) tick();
    tun = $urandom | 32'h0100_0000; vel = 8'd128;
    fd = 1'b1; fa = 1'b1;
    tick();
    fd = 1'b0; fa = 1'b0;
    repeat (6 * NV) begin
      tick();
      total++;
      if (mix !== 24'(exp_out)) begin
        bad++; $display("FAIL collide_tune got=%0d want=%0d cyc=%0d", mix, exp_out, cyc);
      end
    end
    while (cyc % NV != 5) tick();
    note = 1'b0; fa = 1'b1;
    tick();
    fa = 1'b0;
    repeat (4 * NV) begin
      tick();
      total++;
      if (mix !== 24'(exp_out)) begin
        bad++; $display("FAIL collide_gate got=%0d want=%0d cyc=%0d", mix, exp_out, cyc);
      end
    end
  endtask

  task automatic test_random();
    do_reset(3);
    for (int k = 0; k < 60 * NV; k++) begin
      fd = ($urandom_range(0, 7) == 0);
      fa = ($urandom_range(0, 5) == 0);
      idx = 8'($urandom); tun = $urandom;
      note = ($urandom_range(0, 2) != 0); vel = 8'($urandom);
      if (k == 30 * NV + 7) begin
        do_reset(1 + $urandom_range(0, 3));
        total++;
        if (mix !== 24'sd0) begin
          bad++; $display("FAIL midframe_reset got=%0d want=0", mix);
        end
      end
      tick();
      total++;
      if (mix !== 24'(exp_out)) begin
        bad++; $display("FAIL random got=%0d want=%0d cyc=%0d", mix, exp_out, cyc);
      end
    end
    fd = 1'b0; fa = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_note_on();
    test_hold();
    test_note_off();
    test_pair();
    test_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
